// File: rtl/data_ram_ctl.sv
// Parametrised single-port data RAM with byte enables, valid/ready handshake,
// selectable read-during-write and a post-reset clear sequencer.

module data_ram_ctl_lane #(
  parameter int         ADDR_W    = 8,
  parameter int         DEPTH     = 256,
  parameter int         RDW_MODE  = 0,
  parameter logic [7:0] INIT_BYTE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_ptr,
  input  logic              acc_en,
  input  logic              acc_we,
  input  logic              acc_be,
  input  logic              acc_oor,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [7:0]        acc_wdata,
  output logic [7:0]        rbyte
);
  logic [7:0] mem [DEPTH];
  logic       wr_acc;
  logic [7:0] old_byte, new_byte;

  assign wr_acc   = acc_en & acc_we & acc_be & ~acc_oor;
  // Out-of-range accesses read as zero and never touch the array.
  assign old_byte = acc_oor ? 8'h00 : mem[acc_addr];
  assign new_byte = wr_acc ? acc_wdata : old_byte;

  // No reset branch: contents survive rst, only the sequencer rewrites them.
  always_ff @(posedge clk) begin
    if (clr_en)      mem[clr_ptr]  <= INIT_BYTE;
    else if (wr_acc) mem[acc_addr] <= acc_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)         rbyte <= '0;
    else if (acc_en) rbyte <= (RDW_MODE == 1) ? new_byte : old_byte;
  end
endmodule

module data_ram_ctl #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rdata_valid,
  output logic                  init_busy,
  output logic                  err
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                        state, state_nxt;
  logic [ADDR_W-1:0]             ptr, ptr_nxt;
  logic                          clr_en, acc_en, oor;
  logic [NUM_LANES-1:0][7:0]     rd_lanes;
  logic [NUM_LANES-1:0][7:0]     wd_lanes;

  // Compare one bit wider so DEPTH == 2**ADDR_W cannot wrap to zero.
  assign oor       = ({1'b0, addr} >= (ADDR_W+1)'(DEPTH));
  assign req_ready = (state == READY) & ~rst;
  assign init_busy = (state == CLEAR) | rst;
  assign acc_en    = req_valid & req_ready;
  assign wd_lanes  = wdata;
  assign rdata     = rd_lanes;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    clr_en    = 1'b0;
    case (state)
      CLEAR: begin
        clr_en  = ~rst;
        ptr_nxt = ptr + 1'b1;
        if (ptr == LAST) state_nxt = READY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      rdata_valid <= acc_en;
      err         <= acc_en & oor;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    data_ram_ctl_lane #(
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .RDW_MODE  (RDW_MODE),
      .INIT_BYTE (INIT_VAL[8*g +: 8])
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .clr_en    (clr_en),
      .clr_ptr   (ptr),
      .acc_en    (acc_en),
      .acc_we    (we),
      .acc_be    (be[g]),
      .acc_oor   (oor),
      .acc_addr  (addr),
      .acc_wdata (wd_lanes[g]),
      .rbyte     (rd_lanes[g])
    );
  end
endmodule
